// File: rtl/fifo_uart_tx.sv
// Frame transmitter: buffers payload bytes in a FIFO and, on start, streams
// length-hi, length-lo, payload, terminator over a byte valid/ready port.
module fifo_uart_tx #(
  parameter int          DEPTH = 16,
  parameter int          AW    = 4,
  parameter logic [7:0]  TERM  = 8'hBB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic [AW:0]   level,
  input  logic          start,
  output logic          busy,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          done,
  output logic [2:0]    dbg_state
);

  // Output handshake: a byte moves on every cycle with tx_valid && tx_ready.
  // tx_valid is high in every non-IDLE state and tx_data depends only on
  // state/len/FIFO head, so a stalled byte is held stable until accepted.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_TERM   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_q;
  logic [15:0]     len, cnt;
  logic            done_q;
  logic            push, pop;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign level     = level_q;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state;
  assign push      = wr_en && !full;
  assign pop       = (state == S_DATA) && tx_ready;

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b1;
    tx_data   = 8'h00;
    case (state)
      S_IDLE: begin
        tx_valid = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        tx_data = len[15:8];
        if (tx_ready) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        tx_data = len[7:0];
        if (tx_ready) state_nxt = (cnt != 16'd0) ? S_DATA : S_TERM;
      end
      S_DATA: begin
        tx_data = mem[rd_ptr];
        if (tx_ready && cnt == 16'd1) state_nxt = S_TERM;
      end
      S_TERM: begin
        tx_data = TERM;
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: begin
        tx_valid  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Payload storage carries no reset; clearing the pointers discards it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      len     <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_TERM) && tx_ready;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // Length is frozen at acceptance; later pushes wait for the next frame.
      if (state == S_IDLE && start) begin
        len <= 16'(level_q);
        cnt <= 16'(level_q);
      end else if (pop) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: expected frame bytes are queued by hand
// and compared against every accepted output byte.
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic [4:0]  level;
  logic        start;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int last_cycles;
  logic [7:0] exp_q[$];

  fifo_uart_tx #(.DEPTH(16), .AW(4), .TERM(8'hBB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .start(start), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Consumes exp_q; mode 0 = tx_ready always high, mode 1 = pattern 1,0,0.
  task automatic run_frame(input string tag, input int mode);
    int         cyc = 0;
    logic       was_stall = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    while (exp_q.size() > 0 && cyc < 200) begin
      tx_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      check({tag, "_valid"}, 32'(tx_valid), 32'd1);
      if (was_stall) check({tag, "_hold"}, 32'(tx_data), 32'(held));
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        check({tag, "_byte"}, 32'(tx_data), 32'(e));
      end
      was_stall = tx_valid && !tx_ready;
      held      = tx_data;
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    last_cycles = cyc;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_valid_end"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data",  32'(tx_data),  32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_done",  32'(done),     32'd0);
    check("rst_full",  32'(full),     32'd0);
    check("rst_level", 32'(level),    32'd0);

    // 1: four-byte frame, ready held high
    push_byte(8'h03); push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    check("t1_level", 32'(level), 32'd4);
    pulse_start();
    check("t1_lat_valid", 32'(tx_valid), 32'd1);
    check("t1_lat_data",  32'(tx_data),  32'h00);
    exp_q = '{8'h00, 8'h04, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hBB};
    run_frame("t1", 0);
    check("t1_cycles", 32'(last_cycles), 32'd7);
    check("t1_level_end", 32'(level), 32'd0);

    // 2: empty frame, started in the done cycle
    pulse_start();
    exp_q = '{8'h00, 8'h00, 8'hBB};
    run_frame("t2", 0);
    check("t2_cycles", 32'(last_cycles), 32'd3);
    step();
    check("t2_done_clear", 32'(done), 32'd0);

    // 3: backpressure
    push_byte(8'h11); push_byte(8'h22);
    pulse_start();
    exp_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'hBB};
    run_frame("t3", 1);
    step();

    // 4: push and restart mid-frame
    push_byte(8'h11); push_byte(8'h22);
    pulse_start();
    tx_ready = 1'b1;
    check("t4_hi", 32'(tx_data), 32'h00);
    step();
    check("t4_lo", 32'(tx_data), 32'h02);
    wr_en = 1'b1; wr_data = 8'h33; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'hBB};
    run_frame("t4a", 0);
    check("t4_level", 32'(level), 32'd1);
    step();
    check("t4_ignored", 32'(busy), 32'd0);
    pulse_start();
    exp_q = '{8'h00, 8'h01, 8'h33, 8'hBB};
    run_frame("t4b", 0);
    step();

    // 5: overfill
    for (int i = 0; i < 18; i++) begin
      push_byte(8'(8'h40 + i));
      if (i == 14) check("t5_not_full", 32'(full), 32'd0);
      if (i == 15) check("t5_full", 32'(full), 32'd1);
    end
    check("t5_level", 32'(level), 32'd16);
    pulse_start();
    exp_q = '{8'h00, 8'h10};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'hBB);
    run_frame("t5", 0);
    check("t5_cycles", 32'(last_cycles), 32'd19);
    check("t5_level_end", 32'(level), 32'd0);
    step();

    // 6: reset mid-DATA
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    pulse_start();
    tx_ready = 1'b1;
    step(); step();
    check("t6_first_payload", 32'(tx_data), 32'h71);
    step();
    check("t6_second_payload", 32'(tx_data), 32'h72);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_ready = 1'b0;
    check("t6_valid", 32'(tx_valid), 32'd0);
    check("t6_busy",  32'(busy),     32'd0);
    check("t6_level", 32'(level),    32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_done", 32'(done), 32'd0);
      step();
    end
    push_byte(8'h55);
    pulse_start();
    exp_q = '{8'h00, 8'h01, 8'h55, 8'hBB};
    run_frame("t6", 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
